// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file.
package regfile_pkg;
  localparam int XLEN = 32;

  typedef enum logic {
    RF_INIT,
    RF_READY
  } rf_state_e;
endpackage

// File: rtl/regfile_init_seq.sv
// Post-reset clear sequencer: walks every entry to zero, then raises ready.
import regfile_pkg::*;

module regfile_init_seq #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic              o_clr_en,
  output logic [ADDR_W-1:0] o_clr_addr,
  output logic              o_ready,
  output logic              o_init
);
  // state    | meaning
  // RF_INIT  | zeroing entry r_idx this cycle; external writes dropped
  // RF_READY | clear done; normal operation until next reset

  rf_state_e         r_state;
  logic [ADDR_W-1:0] r_idx;
  logic              r_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= RF_INIT;
      r_idx   <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        RF_INIT: begin
          r_idx <= r_idx + ADDR_W'(1);
          if (r_idx == ADDR_W'(DEPTH - 1)) begin
            r_state <= RF_READY;
            r_ready <= 1'b1;
          end
        end
        RF_READY: begin
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= RF_INIT;
          r_idx   <= '0;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign o_init     = (r_state == RF_INIT);
  assign o_clr_en   = (r_state == RF_INIT);
  assign o_clr_addr = r_idx;
  assign o_ready    = r_ready;
endmodule

// File: rtl/regfile_multiport.sv
// Parametrised register file: NUM_RD registered read ports, one write port,
// optional zero entry. Define REGFILE_BYPASS_EN for write-first collisions.
import regfile_pkg::*;

module regfile_multiport #(
  parameter int DATA_W   = XLEN,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_wr_en,
  input  logic [$clog2(DEPTH)-1:0]          i_wr_addr,
  input  logic [DATA_W-1:0]                 i_wr_data,
  input  logic [NUM_RD*$clog2(DEPTH)-1:0]   i_rd_addr,
  output logic [NUM_RD*DATA_W-1:0]          o_rd_data,
  output logic                              o_ready,
  output logic                              o_wr_drop
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_wr_drop;
  logic              w_clr_en;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_init;
  logic              w_zero_wr;
  logic              w_wr_ok;

  regfile_init_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_init_seq (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .o_clr_en   (w_clr_en),
    .o_clr_addr (w_clr_addr),
    .o_ready    (o_ready),
    .o_init     (w_init)
  );

  assign w_zero_wr = (ZERO_REG != 0) && (i_wr_addr == '0);
  assign w_wr_ok   = i_wr_en && !w_init && !w_zero_wr;

  // Storage has no reset; the clear sequencer zeroes it after every reset.
  always_ff @(posedge i_clk) begin
    if (w_clr_en) begin
      r_mem[w_clr_addr] <= '0;
    end else if (w_wr_ok) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_drop <= 1'b0;
    end else begin
      r_wr_drop <= i_wr_en && (w_init || w_zero_wr);
    end
  end

  assign o_wr_drop = r_wr_drop;

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic              w_force_zero;
    logic [DATA_W-1:0] r_rd;

    assign w_ra         = i_rd_addr[gi*ADDR_W +: ADDR_W];
    assign w_force_zero = w_init || ((ZERO_REG != 0) && (w_ra == '0));

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_rd <= '0;
      end else if (w_force_zero) begin
        r_rd <= '0;
`ifdef REGFILE_BYPASS_EN
      end else if (w_wr_ok && (i_wr_addr == w_ra)) begin
        r_rd <= i_wr_data;
`endif
      end else begin
        r_rd <= r_mem[w_ra];
      end
    end

    assign o_rd_data[gi*DATA_W +: DATA_W] = r_rd;
  end
endmodule

// File: tb/tb_regfile_multiport.sv
// Self-checking bench for regfile_multiport (default parameters).
module tb_regfile_multiport;
  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic        ready;
  logic        wr_drop;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_mem [32];
  int          m_edges;

  regfile_multiport dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_rd_addr (rd_addr),
    .o_rd_data (rd_data),
    .o_ready   (ready),
    .o_wr_drop (wr_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit in_init, input bit ok,
                                         input logic [4:0] wa, input logic [31:0] wd);
    if (in_init || a == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (ok && a == wa) return wd;
`endif
    return m_mem[a];
  endfunction

  // One clock: drive, advance past the edge, update model, compare.
  task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [4:0] a0, input logic [4:0] a1);
    bit          in_init, ok;
    logic [31:0] e0, e1;
    logic        ed;
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    rd_addr = {a1, a0};
    in_init = (m_edges < 32);
    ok      = we && !in_init && (wa != 5'd0);
    e0      = exp_rd(a0, in_init, ok, wa, wd);
    e1      = exp_rd(a1, in_init, ok, wa, wd);
    ed      = we && (in_init || wa == 5'd0);
    @(posedge clk);
    #1;
    if (in_init) m_mem[m_edges] = 32'd0;
    else if (ok) m_mem[wa] = wd;
    m_edges++;
    chk("rd0", rd_data[31:0], e0);
    chk("rd1", rd_data[63:32], e1);
    chk("wr_drop", {31'd0, wr_drop}, {31'd0, ed});
    chk("ready", {31'd0, ready}, {31'd0, (m_edges >= 32)});
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    wr_en = 1'b0;
    #2;
    chk("rst_rd0", rd_data[31:0], 32'd0);
    chk("rst_rd1", rd_data[63:32], 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_drop", {31'd0, wr_drop}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst     = 1'b0;
    m_edges = 0;
  endtask

  task automatic sweep();
    for (int a = 0; a < 32; a++) begin
      step(1'b0, 5'd0, 32'd0, 5'(a), 5'(31 - a));
      chk("sweep_zero0", rd_data[31:0], 32'd0);
      chk("sweep_zero1", rd_data[63:32], 32'd0);
    end
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic        ed;
  } vec_t;

  vec_t vt[7];

  initial begin
    vt[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 32'd0,        32'd0,        1'b0};
    vt[1] = '{1'b0, 5'd0, 32'd0,        5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
    vt[2] = '{1'b1, 5'd0, 32'h12345678, 5'd5, 5'd0, 32'hDEADBEEF, 32'd0,        1'b1};
    vt[3] = '{1'b0, 5'd0, 32'd0,        5'd0, 5'd0, 32'd0,        32'd0,        1'b0};
`ifdef REGFILE_BYPASS_EN
    vt[4] = '{1'b1, 5'd7, 32'h11,       5'd7, 5'd1, 32'h11,       32'd0,        1'b0};
    vt[5] = '{1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0};
`else
    vt[4] = '{1'b1, 5'd7, 32'h11,       5'd7, 5'd1, 32'd0,        32'd0,        1'b0};
    vt[5] = '{1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7, 32'h11,       32'h11,       1'b0};
`endif
    vt[6] = '{1'b0, 5'd0, 32'd0,        5'd7, 5'd5, 32'hA5A5A5A5, 32'hDEADBEEF, 1'b0};

    for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
    m_edges = 0;
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    #1;
    do_reset();

    // Clear sequence with a write attempt on the 10th cycle.
    for (int c = 1; c <= 40; c++) begin
      step(c == 10, 5'd20, 32'h0000FFFF, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      if (c == 31) chk("ready_low_edge31", {31'd0, ready}, 32'd0);
      if (c == 32) chk("ready_high_edge32", {31'd0, ready}, 32'd1);
    end
    sweep();

    for (int i = 0; i < 7; i++) begin
      step(vt[i].we, vt[i].wa, vt[i].wd, vt[i].a0, vt[i].a1);
      chk("vec_rd0", rd_data[31:0], vt[i].e0);
      chk("vec_rd1", rd_data[63:32], vt[i].e1);
      chk("vec_drop", {31'd0, wr_drop}, {31'd0, vt[i].ed});
    end

    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end

    // Reset from READY, then again partway through the clear.
    step(1'b1, 5'd3, 32'hCAFEF00D, 5'd3, 5'd0);
    step(1'b0, 5'd0, 32'd0, 5'd3, 5'd3);
    chk("x3_nonzero", rd_data[31:0], 32'hCAFEF00D);
    do_reset();
    for (int c = 1; c <= 15; c++) step(1'b0, 5'd0, 32'd0, 5'd3, 5'd3);
    do_reset();
    for (int c = 1; c <= 32; c++) begin
      step(1'b0, 5'd0, 32'd0, 5'd3, 5'($urandom_range(0, 31)));
      if (c == 31) chk("rerst_ready_low", {31'd0, ready}, 32'd0);
    end
    chk("rerst_ready_high", {31'd0, ready}, 32'd1);
    sweep();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_multiport.md
# regfile_multiport

Parametrised successor to the single-core register file: DATA_W × DEPTH storage with NUM_RD registered read ports, one write port, optional hardwired-zero entry 0 and a post-reset clear sequencer that walks every entry to zero before asserting `ready`. It sits between decode (read addresses) and writeback (write port) in the RV32I datapath. With the default parameters it is a drop-in for the 32×32, two-read-port file.

## Interface
Parameters:
- DATA_W, 32, entry width in bits
- DEPTH, 32, number of entries; power of two, ≥ 2
- NUM_RD, 2, number of read ports, 1–4
- ZERO_REG, 1, when 1, entry 0 reads as zero and writes to it are discarded

Ports (ADDR_W = $clog2(DEPTH)):
- Clock and reset: one clock; reset is asynchronous and active-high.
  - clk, in, 1, rising-edge clock
  - rst, in, 1, asynchronous active-high reset
- Write port:
  - wr_en, in, 1, write strobe (RegWrite)
  - wr_addr, in, ADDR_W, destination (rd)
  - wr_data, in, DATA_W, writeback result
- Read ports:
  - rd_addr, in, NUM_RD*ADDR_W, packed read addresses; port i is at [i*ADDR_W +: ADDR_W]
  - rd_data, out, NUM_RD*DATA_W, packed registered read data, same packing
- Status:
  - ready, out, 1, high once the clear sequence is complete
  - wr_drop, out, 1, one-cycle pulse when a write is discarded (during INIT, or to entry 0 when ZERO_REG=1)

## Operation
- FSM states:
  - INIT: entered on reset. A counter `init_idx` (ADDR_W bits) starts at 0. Each cycle, entry[init_idx] is written with 0 and the counter increments.
  - INIT → READY: on the edge where init_idx == DEPTH-1. `ready` rises on that same edge.
  - READY: holds until the next reset; no other exits.
- Writes:
  - In READY with wr_en=1, entry[wr_addr] ← wr_data on the rising edge.
  - In INIT, wr_en is ignored and wr_drop pulses.
  - With ZERO_REG=1 and wr_addr=0, the write is discarded and wr_drop pulses.
- Reads: every port is independent and may alias any other port. Each cycle, rd_data[i] ← entry[rd_addr[i]] is registered on the edge.
- Forced-zero reads: rd_data[i] is 0 while in INIT, and 0 whenever ZERO_REG=1 and rd_addr[i]=0.
- Read/write collision: a read and a write to the same address on the same edge are governed by the REGFILE_BYPASS_EN macro (see Configuration).
- Reset during INIT or READY:
  - State returns to INIT and init_idx to 0; the sequence restarts from entry 0.
  - Storage contents are not reset directly; the clear sequence zeroes them.
- Widths: addresses wider than ADDR_W are not accepted. DEPTH must be a power of two, so every address is in range.

## Timing
- Reset values: rd_data = 0 (all ports), ready = 0, wr_drop = 0, state = INIT, init_idx = 0.
- Clear latency: ready goes high after the DEPTH-th rising edge following reset deassertion (32 edges at defaults).
- Read latency: 1 cycle. An address presented before edge N produces data valid after edge N.
- Write latency: a write on edge N is visible to reads sampled on edge N+1.
- wr_drop: asserted for exactly the cycle after the dropped write edge.

## Configuration
- `REGFILE_BYPASS_EN` defined (write-first):
  - A read on edge N whose address matches a write on edge N (wr_en=1, READY, and not a dropped entry-0 write) returns wr_data after edge N.
  - Applies to every matching port independently.
- `REGFILE_BYPASS_EN` undefined (read-first): the same read returns the old entry value after edge N; the new value appears one cycle later.

## Structure
- Shared package `regfile_pkg` holds:
  - the state enum `rf_state_e` {RF_INIT, RF_READY}
  - the constant `XLEN = 32`, used as the DATA_W default
- Sub-module `regfile_init_seq` holds the FSM and the init_idx counter. Its outputs are the clear-write enable, clear address, `ready` and the INIT indication. The top level muxes between the clear write and the normal write.

## Test plan
- Reset, then 40 idle cycles → ready rises after edge 32; reads of all 32 addresses return 0.
- In READY, write 0xDEADBEEF to x5, then read x5 on both ports the following cycle → both return 0xDEADBEEF.
- Write 0x12345678 to x0 → wr_drop pulses for one cycle; a subsequent read of x0 returns 0.
- Same-edge write 0xA5A5A5A5 to x7 with rd_addr port0 = 7; x7 previously held 0x11 → returns 0xA5A5A5A5 with REGFILE_BYPASS_EN defined, 0x11 without it.
- wr_en asserted during INIT at cycle 10 → wr_drop pulses; the entry reads 0 after ready.
- Assert rst at INIT cycle 15 while x3 holds nonzero data → ready stays low for 32 edges after deassertion, then all entries read 0.
